// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioner: clock constant,
// millisecond-to-cycle helper and the per-channel event bundle.
package debounce_pkg;

  // Board clock the default timing parameters are derived from.
  localparam longint unsigned DEFAULT_CLK_HZ = 64'd50_000_000;

  // Per-channel event bundle: debounced level plus the three strobes.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic rpt;
  } db_evt_t;

  // Converts a duration in milliseconds into clock cycles at clk_hz.
  function automatic longint unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                   input longint unsigned ms);
    longint unsigned cycles;
    cycles = (clk_hz * ms) / 64'd1000;
    return cycles;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, polarity correction, saturating
// stability counter and optional auto-repeat generator.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   COUNT         = 1000000,
  parameter logic IDLE          = 1'b0,
  parameter int   REPEAT_EN     = 0,
  parameter int   HOLD_CYCLES   = 25000000,
  parameter int   REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rpt_pulse
);

  localparam int CW = $clog2(COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rpt_bit;
  logic                   accept;
  logic                   rise_acc;
  logic                   fall_acc;
  db_evt_t                evt;

  // Synchroniser chain; resets to the idle pin level so reset release is silent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {SYNC_STAGES{IDLE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
    end
  end

  // Polarity-corrected sample: 1 always means pressed.
  assign s = sync[SYNC_STAGES-1] ^ IDLE;

  // A change is accepted once the sample has differed for COUNT cycles.
  assign accept   = (s != level) && (cnt == CNT_LAST);
  assign rise_acc = accept & s;
  assign fall_acc = accept & ~s;

  // Stability counter, accepted level and press/release strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      level  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_acc;
      fall_q <= fall_acc;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int RW   = $clog2(RMAX + 1);
      localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
      localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

      logic [RW-1:0] rc;
      logic          first;
      logic          rpt_q;
      logic          hit;

      // The first repeat waits the longer hold delay, later ones the period.
      assign hit = first ? (rc == HOLD_LAST) : (rc == REP_LAST);

      // Hold timer: restarts on press, free-runs while held, stops on release.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rc    <= '0;
          first <= 1'b1;
          rpt_q <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (rise_acc) begin
            rc    <= '0;
            first <= 1'b1;
          end else if (!level || fall_acc) begin
            rc    <= '0;
            first <= 1'b0;
          end else if (hit) begin
            rpt_q <= 1'b1;
            rc    <= '0;
            first <= 1'b0;
          end else begin
            rc <= rc + 1'b1;
          end
        end
      end

      assign rpt_bit = rpt_q;
    end else begin : g_no_rpt
      assign rpt_bit = 1'b0;
    end
  endgenerate

  // Bundle the registered state into the shared event record.
  assign evt = '{level: level, rise: rise_q, fall: fall_q, rpt: rpt_bit};

  assign level_out  = evt.level;
  assign rise_pulse = evt.rise;
  assign fall_pulse = evt.fall;
  assign rpt_pulse  = evt.rpt;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: one independent debounce_chan
// per button, each with its own pin polarity.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  COUNT         = int'(ms_to_cycles(DEFAULT_CLK_HZ, 64'd20)),
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0,
  parameter int                  REPEAT_EN     = 0,
  parameter int                  HOLD_CYCLES   = int'(ms_to_cycles(DEFAULT_CLK_HZ, 64'd500)),
  parameter int                  REPEAT_CYCLES = int'(ms_to_cycles(DEFAULT_CLK_HZ, 64'd200))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] rpt_pulse
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .COUNT        (COUNT),
        .IDLE         (ACTIVE_LOW[i]),
        .REPEAT_EN    (REPEAT_EN),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_in[i]),
        .level_out (level_out[i]),
        .rise_pulse(rise_pulse[i]),
        .fall_pulse(fall_pulse[i]),
        .rpt_pulse (rpt_pulse[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (COUNT=4, HOLD=10, REPEAT=5).
module tb_debounce_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] level_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic [CH-1:0] rpt_pulse;

  logic [CH-1:0] e_lvl;
  logic [CH-1:0] e_rise;
  logic [CH-1:0] e_fall;
  logic [CH-1:0] e_rpt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS     (4),
    .SYNC_STAGES  (2),
    .COUNT        (4),
    .ACTIVE_LOW   (4'b1000),
    .REPEAT_EN    (1),
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rpt_pulse (rpt_pulse)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held with idle pins, then released: no activity at all.
  task automatic test_reset();
    rst    = 1'b0;
    btn_in = 4'b1000;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 50) rst = 1'b1;
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: lvl=%b rise=%b fall=%b rpt=%b, expected all zero",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse);
      end
    end
  endtask

  // Channel 0 press: accepted 6 edges after the pin change.
  task automatic test_press();
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
      e_lvl[0]  = (k >= 6);
      e_rise[0] = (k == 6);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL press_ch0 edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
    end
  endtask

  // Channel 0 held from acceptance edge E, released after E+40.
  task automatic test_repeat();
    for (int j = 1; j <= 60; j++) begin
      tick();
      e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
      e_lvl[0]  = (j < 46);
      e_rpt[0]  = (j < 46) && (j >= 10) && (((j - 10) % 5) == 0);
      e_fall[0] = (j == 46);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL repeat_ch0 E+%0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 j, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
      if (j == 40) btn_in[0] = 1'b0;
    end
  endtask

  // Channel 1 bounces every 2 cycles, then settles high, then releases.
  task automatic test_bounce();
    for (int c = 0; c < 20; c++) begin
      btn_in[1] = (((c / 2) % 2) == 0);
      tick();
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL bounce_quiet cycle %0d: lvl=%b rise=%b fall=%b rpt=%b, expected all zero",
                 c, level_out, rise_pulse, fall_pulse, rpt_pulse);
      end
    end
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
      e_lvl[1]  = (k >= 6);
      e_rise[1] = (k == 6);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL bounce_settle edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
    end
    btn_in[1] = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
      e_lvl[1]  = (r < 6);
      e_fall[1] = (r == 6);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL bounce_release edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 r, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
    end
  endtask

  // Channel 2: 3-cycle pulse rejected, 4-cycle pulse accepted then released.
  task automatic test_glitch();
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL glitch3 edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected all zero",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse);
      end
      if (k == 3) btn_in[2] = 1'b0;
    end
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
      e_lvl[2]  = (k >= 6) && (k <= 9);
      e_rise[2] = (k == 6);
      e_fall[2] = (k == 10);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL glitch4 edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
      if (k == 4) btn_in[2] = 1'b0;
    end
  endtask

  // All channels pressed, reset at cnt=2, then full re-debounce after release.
  task automatic test_reset_mid();
    btn_in = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL mid_count edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected all zero",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL mid_reset cycle %0d: lvl=%b rise=%b fall=%b rpt=%b, expected all zero",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      e_lvl  = (k >= 6) ? 4'b1111 : 4'b0000;
      e_rise = (k == 6) ? 4'b1111 : 4'b0000;
      e_fall = '0;
      e_rpt  = '0;
      checks++;
      if ({level_out, rise_pulse, fall_pulse, rpt_pulse} !== {e_lvl, e_rise, e_fall, e_rpt}) begin
        errors++;
        $display("[TB] FAIL mid_redebounce edge %0d: lvl=%b rise=%b fall=%b rpt=%b, expected lvl=%b rise=%b fall=%b rpt=%b",
                 k, level_out, rise_pulse, fall_pulse, rpt_pulse, e_lvl, e_rise, e_fall, e_rpt);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'b1000;
    #2;
    $display("[TB] starting debounce_multi bench");
    test_reset();
    test_press();
    test_repeat();
    test_bounce();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
